// File: rtl/general_bring_up_rx.sv
// general_bring_up_rx
//
// Responder side of the RDI general bring-up sideband handshake. Requests
// from the remote partner are decoded, the requested state is reported to
// the RDI controller, and the matching response (or PM_NAK) is returned
// through the local sideband transmitter. Stalled responses are retried.
//
// Handshake: o_tx_msg_valid is raised with o_tx_sb_message stable and is
// held until i_tx_done_send_message is seen (transfer completes on that
// edge) or until the timeout expires. On a timeout, valid drops for one
// cycle and the same message is presented again.
//
// Ports:
//   lclk, sys_rst            clock, synchronous active-high reset
//   i_rx_sb_message/valid    decoded request from the remote sideband
//   i_rdi_allow_rsp          controller permits a non-PM response
//   i_tx_done_send_message   sideband TX accepted the presented message
//   o_tx_sb_message/valid    response towards sideband TX
//   o_rx_busy                request in service (holds off local initiator)
//   o_just_send_responce     one-cycle pulse after a response is sent
//   o_remote_req/_valid      requested state and its update pulse
//   o_rsp_error              sticky, retries exhausted
module general_bring_up_rx #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic       lclk,
  input  logic       sys_rst,
  input  logic [3:0] i_rx_sb_message,
  input  logic       i_rx_msg_valid,
  input  logic       i_rdi_allow_rsp,
  input  logic       i_tx_done_send_message,
  output logic [3:0] o_tx_sb_message,
  output logic       o_tx_msg_valid,
  output logic       o_rx_busy,
  output logic       o_just_send_responce,
  output logic [2:0] o_remote_req,
  output logic       o_remote_req_valid,
  output logic       o_rsp_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_ALLOW = 3'd1,
    ST_SEND       = 3'd2,
    ST_RETRY      = 3'd3,
    ST_RESP_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    code_q, code_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [2:0]    remote_req_q, remote_req_d;
  logic          remote_req_valid_q, remote_req_valid_d;
  logic          rsp_error_q, rsp_error_d;

  logic       req_ok;
  logic [2:0] rx_code;
  logic       rx_is_pm;

  // Response code returned for each request code.
  function automatic logic [3:0] rsp_map(input logic [2:0] c);
    case (c)
      3'd1:       rsp_map = 4'd8;
      3'd2, 3'd3: rsp_map = 4'd9;
      3'd4:       rsp_map = 4'd12;
      3'd5:       rsp_map = 4'd13;
      3'd6:       rsp_map = 4'd14;
      3'd7:       rsp_map = 4'd15;
      default:    rsp_map = 4'd0;
    endcase
  endfunction

  // State reported to the controller for each non-PM request code.
  function automatic logic [2:0] req_map(input logic [2:0] c);
    case (c)
      3'd1:    req_map = 3'd1;
      3'd6:    req_map = 3'd2;
      3'd5:    req_map = 3'd3;
      3'd4:    req_map = 3'd4;
      3'd7:    req_map = 3'd5;
      default: req_map = 3'd0;
    endcase
  endfunction

  // Only request codes 1..7 are meaningful; 0 and responses 8..15 are ignored.
  assign rx_code  = i_rx_sb_message[2:0];
  assign req_ok   = i_rx_msg_valid && !i_rx_sb_message[3] && (rx_code != 3'd0);
  assign rx_is_pm = (rx_code == 3'd2) || (rx_code == 3'd3);

  // State register
  always_ff @(posedge lclk) begin
    if (sys_rst) begin
      state_q            <= ST_IDLE;
      code_q             <= '0;
      timer_q            <= '0;
      retry_q            <= '0;
      remote_req_q       <= '0;
      remote_req_valid_q <= 1'b0;
      rsp_error_q        <= 1'b0;
    end else begin
      state_q            <= state_d;
      code_q             <= code_d;
      timer_q            <= timer_d;
      retry_q            <= retry_d;
      remote_req_q       <= remote_req_d;
      remote_req_valid_q <= remote_req_valid_d;
      rsp_error_q        <= rsp_error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d            = state_q;
    code_d             = code_q;
    timer_d            = timer_q;
    retry_d            = retry_q;
    remote_req_d       = remote_req_q;
    remote_req_valid_d = 1'b0;
    rsp_error_d        = rsp_error_q;
    case (state_q)
      ST_IDLE, ST_RESP_DONE: begin
        state_d = ST_IDLE;
        if (req_ok) begin
          code_d      = rx_code;
          timer_d     = '0;
          retry_d     = '0;
          rsp_error_d = 1'b0;
          if (rx_is_pm) begin
            // PM requests are always NAKed without asking the controller.
            state_d = ST_SEND;
          end else begin
            state_d            = ST_WAIT_ALLOW;
            remote_req_d       = req_map(rx_code);
            remote_req_valid_d = 1'b1;
          end
        end
      end
      ST_WAIT_ALLOW: begin
        // LINKERROR overrides whatever is pending, even if allow is high
        // in the same cycle; the controller must re-grant for the new request.
        if (req_ok && (rx_code == 3'd5)) begin
          code_d             = 3'd5;
          remote_req_d       = 3'd3;
          remote_req_valid_d = 1'b1;
        end else if (i_rdi_allow_rsp) begin
          state_d = ST_SEND;
          timer_d = '0;
        end
      end
      ST_SEND: begin
        if (i_tx_done_send_message) begin
          state_d = ST_RESP_DONE;
        end else if (timer_q == TMR_LAST) begin
          if (retry_q < RETRY_MAX) begin
            state_d = ST_RETRY;
            retry_d = retry_q + 1'b1;
          end else begin
            state_d     = ST_IDLE;
            rsp_error_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RETRY: begin
        state_d = ST_SEND;
        timer_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_tx_sb_message      = 4'd0;
    o_tx_msg_valid       = 1'b0;
    o_rx_busy            = 1'b0;
    o_just_send_responce = 1'b0;
    case (state_q)
      ST_WAIT_ALLOW: o_rx_busy = 1'b1;
      ST_SEND: begin
        o_rx_busy       = 1'b1;
        o_tx_msg_valid  = 1'b1;
        o_tx_sb_message = rsp_map(code_q);
      end
      ST_RETRY:     o_rx_busy = 1'b1;
      ST_RESP_DONE: o_just_send_responce = 1'b1;
      default: ;
    endcase
  end

  assign o_remote_req       = remote_req_q;
  assign o_remote_req_valid = remote_req_valid_q;
  assign o_rsp_error        = rsp_error_q;

endmodule

// File: tb/tb_general_bring_up_rx.sv
module tb_general_bring_up_rx;

  logic       lclk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [3:0] i_rx_sb_message = 4'd0;
  logic       i_rx_msg_valid = 1'b0;
  logic       i_rdi_allow_rsp = 1'b0;
  logic       i_tx_done_send_message = 1'b0;
  logic [3:0] o_tx_sb_message;
  logic       o_tx_msg_valid;
  logic       o_rx_busy;
  logic       o_just_send_responce;
  logic [2:0] o_remote_req;
  logic       o_remote_req_valid;
  logic       o_rsp_error;

  int tests_run = 0;
  int tests_failed = 0;

  // Scoreboard queues: driver pushes, monitor pops on DUT output events.
  logic [2:0] exp_req_q[$];
  logic [3:0] exp_tx_q[$];
  logic [0:0] exp_done_q[$];

  general_bring_up_rx #(.TIMEOUT_CYCLES(4), .MAX_RETRY(2)) dut (
    .lclk                   (lclk),
    .sys_rst                (sys_rst),
    .i_rx_sb_message        (i_rx_sb_message),
    .i_rx_msg_valid         (i_rx_msg_valid),
    .i_rdi_allow_rsp        (i_rdi_allow_rsp),
    .i_tx_done_send_message (i_tx_done_send_message),
    .o_tx_sb_message        (o_tx_sb_message),
    .o_tx_msg_valid         (o_tx_msg_valid),
    .o_rx_busy              (o_rx_busy),
    .o_just_send_responce   (o_just_send_responce),
    .o_remote_req           (o_remote_req),
    .o_remote_req_valid     (o_remote_req_valid),
    .o_rsp_error            (o_rsp_error)
  );

  // Clock / reset
  always #5 lclk = ~lclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge lclk);
    #1;
  endtask

  task automatic send_req(input logic [3:0] code);
    i_rx_sb_message = code;
    i_rx_msg_valid  = 1'b1;
    tick();
    i_rx_msg_valid  = 1'b0;
    i_rx_sb_message = 4'd0;
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_all0"}, {o_tx_sb_message, o_tx_msg_valid, o_rx_busy, o_just_send_responce,
                          o_remote_req, o_remote_req_valid, o_rsp_error}, 32'd0);
  endtask

  // Monitor: pops expected values when the DUT presents an output event.
  logic prev_valid = 1'b0;
  always @(negedge lclk) begin
    if (o_remote_req_valid) begin
      if (exp_req_q.size() == 0) chk("mon_unexpected_remote_req", 32'(o_remote_req), 32'd0);
      else chk("mon_remote_req", 32'(o_remote_req), 32'(exp_req_q.pop_front()));
    end
    if (o_tx_msg_valid && !prev_valid) begin
      if (exp_tx_q.size() == 0) chk("mon_unexpected_tx", 32'(o_tx_sb_message), 32'd0);
      else chk("mon_tx_msg", 32'(o_tx_sb_message), 32'(exp_tx_q.pop_front()));
    end
    if (o_just_send_responce) begin
      if (exp_done_q.size() == 0) chk("mon_unexpected_done", 32'd1, 32'd0);
      else begin
        void'(exp_done_q.pop_front());
        chk("mon_done_tx_clear", {27'd0, o_tx_msg_valid, o_tx_sb_message}, 32'd0);
      end
    end
    prev_valid = o_tx_msg_valid;
  end

  // Expected valid pattern for T=4, MAX_RETRY=2: 4 high, 1 low, 4 high, 1 low, 4 high.
  function automatic logic exp_valid_at(input int i);
    return (i < 4) || (i >= 5 && i < 9) || (i >= 10);
  endfunction

  initial begin
    // Reset
    tick(); tick(); tick();
    chk_idle_outputs("reset");
    sys_rst = 1'b0;
    tick();
    chk_idle_outputs("post_reset");

    // Ignored codes
    send_req(4'd12);
    chk("ign12_busy", 32'(o_rx_busy), 32'd0);
    send_req(4'd0);
    chk("ign0_busy", 32'(o_rx_busy), 32'd0);

    // RETRAIN with allow high, done after 3 valid cycles
    i_rdi_allow_rsp = 1'b1;
    exp_req_q.push_back(3'd2); exp_tx_q.push_back(4'd14); exp_done_q.push_back(1'b1);
    send_req(4'd6);
    chk("rt_busy", 32'(o_rx_busy), 32'd1);
    chk("rt_req_valid", 32'(o_remote_req_valid), 32'd1);
    chk("rt_tx_valid_n1", 32'(o_tx_msg_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rt_tx_valid", 32'(o_tx_msg_valid), 32'd1);
      chk("rt_tx_msg", 32'(o_tx_sb_message), 32'd14);
      chk("rt_busy_send", 32'(o_rx_busy), 32'd1);
    end
    i_tx_done_send_message = 1'b1;
    tick();
    i_tx_done_send_message = 1'b0;
    chk("rt_just_sent", 32'(o_just_send_responce), 32'd1);
    chk("rt_busy_done", 32'(o_rx_busy), 32'd0);
    chk("rt_valid_done", 32'(o_tx_msg_valid), 32'd0);
    tick();
    chk("rt_just_sent_pulse", 32'(o_just_send_responce), 32'd0);
    chk("rt_req_hold", 32'(o_remote_req), 32'd2);

    // L1 with allow low: immediate PM_NAK, no remote_req update
    i_rdi_allow_rsp = 1'b0;
    exp_tx_q.push_back(4'd9); exp_done_q.push_back(1'b1);
    send_req(4'd2);
    chk("l1_valid", 32'(o_tx_msg_valid), 32'd1);
    chk("l1_msg", 32'(o_tx_sb_message), 32'd9);
    chk("l1_no_req_valid", 32'(o_remote_req_valid), 32'd0);
    chk("l1_req_hold", 32'(o_remote_req), 32'd2);
    i_tx_done_send_message = 1'b1;
    tick();
    i_tx_done_send_message = 1'b0;
    chk("l1_just_sent", 32'(o_just_send_responce), 32'd1);
    tick();

    // ACTIVE, preempted by LINKERROR, DISABLE dropped, then allow
    exp_req_q.push_back(3'd1);
    send_req(4'd1);
    chk("act_req", 32'(o_remote_req), 32'd1);
    tick(); tick();
    chk("act_wait_busy", 32'(o_rx_busy), 32'd1);
    chk("act_wait_novalid", 32'(o_tx_msg_valid), 32'd0);
    exp_req_q.push_back(3'd3);
    send_req(4'd5);
    chk("le_req", 32'(o_remote_req), 32'd3);
    chk("le_req_valid", 32'(o_remote_req_valid), 32'd1);
    send_req(4'd7);
    chk("dis_drop_valid", 32'(o_remote_req_valid), 32'd0);
    chk("dis_drop_req", 32'(o_remote_req), 32'd3);
    i_rdi_allow_rsp = 1'b1;
    exp_tx_q.push_back(4'd13); exp_done_q.push_back(1'b1);
    tick();
    chk("le_msg", 32'(o_tx_sb_message), 32'd13);
    i_tx_done_send_message = 1'b1;
    tick();
    i_tx_done_send_message = 1'b0;
    chk("le_just_sent", 32'(o_just_send_responce), 32'd1);
    tick();

    // Timeout: done never asserted, retries exhausted
    exp_req_q.push_back(3'd4);
    for (int i = 0; i < 3; i++) exp_tx_q.push_back(4'd12);
    send_req(4'd4);
    tick();
    for (int i = 0; i < 14; i++) begin
      chk("to_valid_pattern", 32'(o_tx_msg_valid), 32'(exp_valid_at(i)));
      chk("to_busy", 32'(o_rx_busy), 32'd1);
      chk("to_err_low", 32'(o_rsp_error), 32'd0);
      tick();
    end
    chk("to_error", 32'(o_rsp_error), 32'd1);
    chk("to_busy_end", 32'(o_rx_busy), 32'd0);
    chk("to_valid_end", 32'(o_tx_msg_valid), 32'd0);
    tick();
    chk("to_error_sticky", 32'(o_rsp_error), 32'd1);

    // Done coincident with the final timeout cycle of the last retry
    exp_req_q.push_back(3'd1); exp_done_q.push_back(1'b1);
    for (int i = 0; i < 3; i++) exp_tx_q.push_back(4'd8);
    send_req(4'd1);
    chk("err_cleared", 32'(o_rsp_error), 32'd0);
    tick();
    for (int i = 0; i < 14; i++) begin
      chk("dc_valid_pattern", 32'(o_tx_msg_valid), 32'(exp_valid_at(i)));
      if (i == 13) i_tx_done_send_message = 1'b1;
      tick();
    end
    i_tx_done_send_message = 1'b0;
    chk("dc_just_sent", 32'(o_just_send_responce), 32'd1);
    chk("dc_no_error", 32'(o_rsp_error), 32'd0);
    tick();

    // Reset during SEND
    exp_tx_q.push_back(4'd9);
    send_req(4'd3);
    chk("rs_send", 32'(o_tx_msg_valid), 32'd1);
    sys_rst = 1'b1;
    tick();
    chk_idle_outputs("rs_mid");
    sys_rst = 1'b0;
    tick();
    chk_idle_outputs("rs_after");

    // DISABLE captured in the RESP_DONE cycle
    exp_req_q.push_back(3'd2); exp_tx_q.push_back(4'd14); exp_done_q.push_back(1'b1);
    send_req(4'd6);
    tick();
    i_tx_done_send_message = 1'b1;
    tick();
    i_tx_done_send_message = 1'b0;
    chk("rd_just_sent", 32'(o_just_send_responce), 32'd1);
    exp_req_q.push_back(3'd5); exp_tx_q.push_back(4'd15); exp_done_q.push_back(1'b1);
    send_req(4'd7);
    chk("rd_dis_req", 32'(o_remote_req), 32'd5);
    chk("rd_dis_req_valid", 32'(o_remote_req_valid), 32'd1);
    chk("rd_dis_busy", 32'(o_rx_busy), 32'd1);
    tick();
    chk("rd_dis_msg", 32'(o_tx_sb_message), 32'd15);
    i_tx_done_send_message = 1'b1;
    tick();
    i_tx_done_send_message = 1'b0;
    tick(); tick();

    // Final report
    chk("left_req_q", 32'(exp_req_q.size()), 32'd0);
    chk("left_tx_q", 32'(exp_tx_q.size()), 32'd0);
    chk("left_done_q", 32'(exp_done_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/general_bring_up_rx.md
# general_bring_up_rx

Responder side of the RDI general bring-up sideband handshake. It decodes request messages arriving from the remote partner's sideband, reports the requested state to the RDI controller, and returns the matching response (or PM_NAK) through the local sideband transmitter. It holds off the local initiator through `o_rx_busy` and retries stalled responses. It sits between the sideband RX/TX message ports and the RDI controller, alongside the local bring-up initiator.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: cycles `o_tx_msg_valid` is held without `i_tx_done_send_message` before a retry; minimum 2.
- MAX_RETRY, 3: retries allowed before the error flag is raised.

Ports:
- lclk  in  1  clock.
- sys_rst  in  1  synchronous reset, active-high.
- i_rx_sb_message  in  4  decoded sideband message from the remote partner.
- i_rx_msg_valid  in  1  qualifies `i_rx_sb_message` for one cycle.
- i_rdi_allow_rsp  in  1  level; controller permits a response to a non-PM request.
- i_tx_done_send_message  in  1  sideband TX has sent the message currently presented.
- o_tx_sb_message  out  4  response message to sideband TX.
- o_tx_msg_valid  out  1  qualifies `o_tx_sb_message`.
- o_rx_busy  out  1  a request is being serviced; feeds the initiator's RX-busy input.
- o_just_send_responce  out  1  one-cycle pulse after a response is sent.
- o_remote_req  out  3  requested state: 1 ACTIVE, 2 RETRAIN, 3 LINKERROR, 4 LINKRESET, 5 DISABLE, 0 none.
- o_remote_req_valid  out  1  one-cycle pulse when `o_remote_req` updates.
- o_rsp_error  out  1  sticky; retries exhausted.

## Operation
Message codes:
- Requests: ACTIVE_REQ 1, L1_REQ 2, L2_REQ 3, LINKRESET_REQ 4, LINKERROR_REQ 5, RETRAIN_REQ 6, DISABLE_REQ 7.
- Responses: ACTIVE_RSP 8, PM_NAK 9, LINKRESET_RSP 12, LINKERROR_RSP 13, RETRAIN_RSP 14, DISABLE_RSP 15.

Response mapping: 1→8, 2→9, 3→9, 4→12, 5→13, 6→14, 7→15.

Request mapping for `o_remote_req`: 1→1, 6→2, 5→3, 4→4, 7→5. L1/L2 do not update it.

Capture:
- A request is captured only in IDLE or RESP_DONE, when `i_rx_msg_valid`=1 and the code is 1..7.
- Codes 0 and 8..15 are ignored in every state.

States:
- IDLE: on capture, latch the code and reset the retry count.
  - Code 2 or 3 → SEND.
  - Otherwise → WAIT_ALLOW; `o_remote_req` is loaded and `o_remote_req_valid` pulses.
- WAIT_ALLOW: `i_rdi_allow_rsp`=1 → SEND. A LINKERROR_REQ arriving here preempts the pending request: the latch is replaced, `o_remote_req`=3 with a pulse, and the state stays WAIT_ALLOW. Any other request arriving here is dropped.
- SEND: `o_tx_msg_valid`=1 with the mapped response; the timer counts from 0.
  - `i_tx_done_send_message`=1 → RESP_DONE. Done takes priority over timeout in the same cycle.
  - Timer reaches TIMEOUT_CYCLES-1 without done, and retry count < MAX_RETRY → RETRY; increment retry count.
  - Timer reaches TIMEOUT_CYCLES-1 without done, and retries are exhausted → IDLE; set `o_rsp_error`.
- RETRY: valid is low for one cycle, then SEND with the timer cleared.
- RESP_DONE: one cycle.
  - `o_just_send_responce`=1, `o_tx_msg_valid`=0, `o_tx_sb_message`=0.
  - A capture here behaves as in IDLE; otherwise → IDLE.

Other rules:
- `o_rx_busy`=1 in WAIT_ALLOW, SEND and RETRY; 0 in IDLE and RESP_DONE.
- `o_rsp_error` clears on the next capture.
- `o_remote_req` holds until the next non-PM capture or reset.

## Timing
- All outputs are registered and decoded from the state register.
- Reset: synchronous. Every output is 0, state is IDLE, and the latch, timer and retry count clear. Reset asserted mid-operation drops the pending request and zeroes all outputs at the next edge.
- Request valid sampled at edge N:
  - At N+1: `o_rx_busy`=1 and the `o_remote_req_valid` pulse.
  - With allow already high: `o_tx_msg_valid`=1 at N+2.
  - PM request: `o_tx_msg_valid`=1 at N+1.
- Done sampled at edge M: at M+1, valid=0, `o_rx_busy`=0 and `o_just_send_responce`=1 for one cycle.
- Without done, valid is high for exactly TIMEOUT_CYCLES cycles, then low for 1 cycle per retry.
- Worst case before error: (MAX_RETRY+1)·TIMEOUT_CYCLES + MAX_RETRY cycles in SEND/RETRY.
- Timer width is clog2(TIMEOUT_CYCLES); retry counter width is clog2(MAX_RETRY+1). Neither wraps.

## Test plan
- RETRAIN_REQ (6), allow high, done 3 cycles after valid → `o_remote_req`=2 pulse; `o_tx_sb_message`=14 for 3 cycles; one `o_just_send_responce` pulse; busy high for 4 cycles.
- L1_REQ (2) with allow low → `o_tx_sb_message`=9 at N+1; no `o_remote_req_valid`.
- ACTIVE_REQ, then LINKERROR_REQ in WAIT_ALLOW, then allow → `o_remote_req` goes 1→3; response 13 sent. DISABLE_REQ in WAIT_ALLOW → ignored.
- TIMEOUT_CYCLES=4, MAX_RETRY=2, done never asserted → valid pattern 4 high/1 low ×2, then 4 high; `o_rsp_error`=1; busy 0.
- Done coincident with the final timeout cycle → RESP_DONE taken; no error.
- Reset asserted during SEND → all outputs 0 next cycle. A new DISABLE_REQ arriving in the RESP_DONE cycle is captured (`o_remote_req`=5).
